// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic                wen;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wmask;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side handshake bundle; slave is the arbiter's view, master the environment's.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
  ();

  logic                i_req_valid;
  logic                i_req_ready;
  logic [ADDR_W-1:0]   i_req_addr;
  logic                i_resp_valid;
  logic [DATA_W-1:0]   i_resp_rdata;
  logic                i_flush;

  logic                d_req_valid;
  logic                d_req_ready;
  logic                d_req_wen;
  logic [ADDR_W-1:0]   d_req_addr;
  logic [DATA_W-1:0]   d_req_wdata;
  logic [DATA_W/8-1:0] d_req_wmask;
  logic                d_resp_valid;
  logic [DATA_W-1:0]   d_resp_rdata;

  logic                mem_cmd_valid;
  logic                mem_cmd_ready;
  logic                mem_cmd_wen;
  logic [ADDR_W-1:0]   mem_cmd_addr;
  logic [DATA_W-1:0]   mem_cmd_wdata;
  logic [DATA_W/8-1:0] mem_cmd_wmask;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_resp_rdata;

  modport slave (
    input  i_req_valid, i_req_addr, i_flush,
    output i_req_ready, i_resp_valid, i_resp_rdata,
    input  d_req_valid, d_req_wen, d_req_addr, d_req_wdata, d_req_wmask,
    output d_req_ready, d_resp_valid, d_resp_rdata,
    output mem_cmd_valid, mem_cmd_wen, mem_cmd_addr, mem_cmd_wdata, mem_cmd_wmask,
    input  mem_cmd_ready, mem_resp_valid, mem_resp_rdata
  );

  modport master (
    output i_req_valid, i_req_addr, i_flush,
    input  i_req_ready, i_resp_valid, i_resp_rdata,
    output d_req_valid, d_req_wen, d_req_addr, d_req_wdata, d_req_wmask,
    input  d_req_ready, d_resp_valid, d_resp_rdata,
    input  mem_cmd_valid, mem_cmd_wen, mem_cmd_addr, mem_cmd_wdata, mem_cmd_wmask,
    output mem_cmd_ready, mem_resp_valid, mem_resp_rdata
  );

endinterface

// File: rtl/mem_arb_picker.sv
// Winner selection between fetch and data requesters. Default: D priority with an I starvation
// guard; with ARB_ROUND_ROBIN_EN defined, contested grants alternate instead.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_en,
  input  logic i_req_valid,
  input  logic d_req_valid,
  output logic grant_i,
  output logic grant_d
);

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t rr_last_reg, rr_last_next;

  always_comb begin
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    rr_last_next = rr_last_reg;
    if (grant_en) begin
      if (i_req_valid && d_req_valid) begin
        grant_d = (rr_last_reg == OWN_I);
        grant_i = (rr_last_reg == OWN_D);
      end else begin
        grant_i = i_req_valid;
        grant_d = d_req_valid;
      end
      if (grant_i) rr_last_next = OWN_I;
      else if (grant_d) rr_last_next = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_last_reg <= OWN_I;
    else       rr_last_reg <= rr_last_next;
  end
`else
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_reg, streak_next;

  always_comb begin
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    streak_next = streak_reg;
    if (grant_en) begin
      if (i_req_valid && d_req_valid) begin
        grant_i = (streak_reg == STREAK_MAX);
        grant_d = (streak_reg != STREAK_MAX);
      end else begin
        grant_i = i_req_valid;
        grant_d = d_req_valid;
      end
      // Only D grants that kept a waiting fetch out count toward starvation.
      if (grant_i) streak_next = '0;
      else if (grant_d && i_req_valid && streak_reg != STREAK_MAX)
        streak_next = streak_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) streak_reg <= '0;
    else       streak_reg <= streak_next;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port shared by fetch (I) and data (D) requesters; routes each
// response to the owner. Grant policy selectable with ARB_ROUND_ROBIN_EN (see mem_arb_picker).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  arb_state_t state_reg, state_next;
  arb_owner_t owner_reg, owner_next;
  mem_cmd_t   cmd_reg, cmd_next;
  logic       drop_reg, drop_next;
  logic       grant_i, grant_d;

  mem_arb_picker #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_picker (
    .clk         (clk),
    .reset       (reset),
    .grant_en    (state_reg == IDLE && !reset),
    .i_req_valid (bus.i_req_valid),
    .d_req_valid (bus.d_req_valid),
    .grant_i     (grant_i),
    .grant_d     (grant_d)
  );

  assign bus.mem_cmd_wen   = cmd_reg.wen;
  assign bus.mem_cmd_addr  = cmd_reg.addr;
  assign bus.mem_cmd_wdata = cmd_reg.wdata;
  assign bus.mem_cmd_wmask = cmd_reg.wmask;

  always_comb begin
    state_next        = state_reg;
    owner_next        = owner_reg;
    cmd_next          = cmd_reg;
    drop_next         = drop_reg;
    bus.i_req_ready   = 1'b0;
    bus.d_req_ready   = 1'b0;
    bus.mem_cmd_valid = 1'b0;
    bus.i_resp_valid  = 1'b0;
    bus.i_resp_rdata  = '0;
    bus.d_resp_valid  = 1'b0;
    bus.d_resp_rdata  = '0;

    case (state_reg)
      IDLE: begin
        drop_next = 1'b0;
        if (grant_d) begin
          bus.d_req_ready = 1'b1;
          cmd_next.wen    = bus.d_req_wen;
          cmd_next.addr   = bus.d_req_addr;
          cmd_next.wdata  = bus.d_req_wdata;
          cmd_next.wmask  = bus.d_req_wmask;
          owner_next      = OWN_D;
          state_next      = ISSUE;
        end else if (grant_i) begin
          bus.i_req_ready = 1'b1;
          cmd_next.wen    = 1'b0;
          cmd_next.addr   = bus.i_req_addr;
          cmd_next.wdata  = '0;
          cmd_next.wmask  = '0;
          owner_next      = OWN_I;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_cmd_valid = 1'b1;
        if (bus.mem_cmd_ready) state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (bus.mem_resp_valid) begin
          state_next = IDLE;
          if (owner_reg == OWN_D) begin
            bus.d_resp_valid = 1'b1;
            bus.d_resp_rdata = bus.mem_resp_rdata;
          end else if (!drop_reg && !bus.i_flush) begin
            // A flush landing on the response cycle itself also suppresses delivery.
            bus.i_resp_valid = 1'b1;
            bus.i_resp_rdata = bus.mem_resp_rdata;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_reg != IDLE && state_next != IDLE && owner_reg == OWN_I && bus.i_flush)
      drop_next = 1'b1;
    if (state_next == IDLE)
      drop_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= OWN_I;
      cmd_reg   <= '0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      cmd_reg   <= cmd_next;
      drop_reg  <= drop_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expected grant orders differ when ARB_ROUND_ROBIN_EN is defined.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MAX_D_STREAK (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at an IDLE cycle with requests already driven; returns at the following IDLE cycle.
  task automatic run_txn(input string tag, input logic exp_gi, input logic [31:0] exp_addr,
                         input logic [31:0] rdata);
    #1;
    check({tag, "_i_ready"}, bus.i_req_ready, exp_gi);
    check({tag, "_d_ready"}, bus.d_req_ready, !exp_gi);
    tick();
    bus.mem_cmd_ready = 1'b1;
    #1;
    check({tag, "_cmd_valid"}, bus.mem_cmd_valid, 1'b1);
    check({tag, "_cmd_addr"}, bus.mem_cmd_addr, exp_addr);
    tick();
    bus.mem_cmd_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = rdata;
    #1;
    check({tag, "_i_resp"}, bus.i_resp_valid, exp_gi);
    check({tag, "_d_resp"}, bus.d_resp_valid, !exp_gi);
    $display("txn %s: grant=%s addr=%0h rdata=%0h", tag, exp_gi ? "I" : "D", exp_addr, rdata);
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask

  initial begin
    logic exp_i_seq [10];
`ifdef ARB_ROUND_ROBIN_EN
    // The D write just before leaves rr_last at D, so the contested run starts with I.
    exp_i_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_i_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

    reset              = 1'b1;
    bus.i_req_valid    = 1'b0;
    bus.i_req_addr     = '0;
    bus.i_flush        = 1'b0;
    bus.d_req_valid    = 1'b0;
    bus.d_req_wen      = 1'b0;
    bus.d_req_addr     = '0;
    bus.d_req_wdata    = '0;
    bus.d_req_wmask    = '0;
    bus.mem_cmd_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;

    // Reset state
    tick();
    tick();
    #1;
    check("rst_state", 64'(dut.state_reg), 64'(IDLE));
    check("rst_cmd_valid", bus.mem_cmd_valid, 1'b0);
    check("rst_cmd_addr", bus.mem_cmd_addr, 32'h0);
    check("rst_ready", {bus.i_req_ready, bus.d_req_ready}, 2'b00);
    check("rst_resp", {bus.i_resp_valid, bus.d_resp_valid, bus.d_resp_rdata}, 34'h0);
    $display("txn reset: outputs idle");
    reset = 1'b0;
    tick();

    // 1: lone D write, single-cycle memory
    bus.d_req_valid = 1'b1;
    bus.d_req_wen   = 1'b1;
    bus.d_req_addr  = 32'h100;
    bus.d_req_wdata = 32'hDEADBEEF;
    bus.d_req_wmask = 4'hF;
    #1;
    check("t1_d_ready", bus.d_req_ready, 1'b1);
    check("t1_cmd_valid_c0", bus.mem_cmd_valid, 1'b0);
    tick();
    bus.d_req_valid   = 1'b0;
    bus.mem_cmd_ready = 1'b1;
    #1;
    check("t1_cmd_valid", bus.mem_cmd_valid, 1'b1);
    check("t1_cmd_fields", {bus.mem_cmd_wen, bus.mem_cmd_addr, bus.mem_cmd_wdata, bus.mem_cmd_wmask},
          {1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
    tick();
    bus.mem_cmd_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h0;
    #1;
    check("t1_d_resp", bus.d_resp_valid, 1'b1);
    check("t1_i_resp", bus.i_resp_valid, 1'b0);
    check("t1_cmd_dropped", bus.mem_cmd_valid, 1'b0);
    $display("txn t1: D write 100 acked");
    tick();
    bus.mem_resp_valid = 1'b0;

    // 2: both requesters held valid
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h400;
    bus.d_req_valid = 1'b1;
    bus.d_req_wen   = 1'b0;
    bus.d_req_addr  = 32'h300;
    for (int k = 0; k < 10; k++)
      run_txn($sformatf("t2_g%0d", k), exp_i_seq[k], exp_i_seq[k] ? 32'h400 : 32'h300, 32'(k));

    // 3: command held back by memory for 5 cycles
    bus.i_req_valid = 1'b0;
    bus.d_req_addr  = 32'h500;
    #1;
    check("t3_d_ready", bus.d_req_ready, 1'b1);
    tick();
    bus.d_req_valid = 1'b0;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h200;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("t3_hold%0d", c), {bus.mem_cmd_valid, bus.mem_cmd_addr, bus.mem_cmd_wen},
            {1'b1, 32'h500, 1'b0});
      check($sformatf("t3_noready%0d", c), {bus.i_req_ready, bus.d_req_ready}, 2'b00);
      tick();
    end
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.mem_cmd_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h55;
    #1;
    check("t3_d_resp", {bus.d_resp_valid, bus.d_resp_rdata}, {1'b1, 32'h55});
    check("t3_i_wait", bus.i_req_ready, 1'b0);
    $display("txn t3: D read 500 after stall, rdata=55");
    tick();
    bus.mem_resp_valid = 1'b0;

    // 4: flushed fetch, then a normal fetch
    #1;
    check("t4_i_ready", bus.i_req_ready, 1'b1);
    tick();
    bus.i_req_addr    = 32'h204;
    bus.mem_cmd_ready = 1'b1;
    #1;
    check("t4_cmd_addr", {bus.mem_cmd_wen, bus.mem_cmd_addr}, {1'b0, 32'h200});
    tick();
    bus.mem_cmd_ready = 1'b0;
    bus.i_flush       = 1'b1;
    tick();
    bus.i_flush        = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h12345678;
    #1;
    check("t4_flushed", {bus.i_resp_valid, bus.i_resp_rdata}, 33'h0);
    check("t4_no_d_resp", bus.d_resp_valid, 1'b0);
    $display("txn t4a: I read 200 flushed");
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    check("t4_regrant", bus.i_req_ready, 1'b1);
    tick();
    bus.i_req_valid   = 1'b0;
    bus.mem_cmd_ready = 1'b1;
    #1;
    check("t4_cmd_addr2", bus.mem_cmd_addr, 32'h204);
    tick();
    bus.mem_cmd_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hCAFEF00D;
    #1;
    check("t4_i_resp", {bus.i_resp_valid, bus.i_resp_rdata}, {1'b1, 32'hCAFEF00D});
    $display("txn t4b: I read 204 rdata=cafef00d");
    tick();
    bus.mem_resp_valid = 1'b0;

    // 5: reset while in ISSUE, then a stray response
    bus.d_req_valid = 1'b1;
    bus.d_req_wen   = 1'b1;
    bus.d_req_addr  = 32'h600;
    bus.d_req_wdata = 32'h11112222;
    bus.d_req_wmask = 4'h3;
    #1;
    check("t5_d_ready", bus.d_req_ready, 1'b1);
    tick();
    bus.d_req_valid = 1'b0;
    #1;
    check("t5_issue", bus.mem_cmd_valid, 1'b1);
    reset = 1'b1;
    tick();
    #1;
    check("t5_rst_state", 64'(dut.state_reg), 64'(IDLE));
    check("t5_rst_cmd", {bus.mem_cmd_valid, bus.mem_cmd_wen, bus.mem_cmd_addr, bus.mem_cmd_wdata},
          66'h0);
    reset = 1'b0;
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h77;
    #1;
    check("t5_stray", {bus.i_resp_valid, bus.d_resp_valid, bus.d_resp_rdata}, 34'h0);
    $display("txn t5: reset in ISSUE, stray response ignored");
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    check("t5_still_idle", 64'(dut.state_reg), 64'(IDLE));

    // 6: contested grants from a fresh reset
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h700;
    bus.d_req_valid = 1'b1;
    bus.d_req_wen   = 1'b0;
    bus.d_req_addr  = 32'h800;
`ifdef ARB_ROUND_ROBIN_EN
    run_txn("t6_rr0", 1'b0, 32'h800, 32'h60);
    run_txn("t6_rr1", 1'b1, 32'h700, 32'h61);
    run_txn("t6_rr2", 1'b0, 32'h800, 32'h62);
    run_txn("t6_rr3", 1'b1, 32'h700, 32'h63);
`else
    for (int k = 0; k < 4; k++)
      run_txn($sformatf("t6_d%0d", k), 1'b0, 32'h800, 32'(k));
    check("t6_streak_sat", dut.u_picker.streak_reg, 4'd4);
    bus.d_req_valid = 1'b0;
    run_txn("t6_lone_i", 1'b1, 32'h700, 32'h66);
    #1;
    check("t6_streak_clr", dut.u_picker.streak_reg, 4'd0);
`endif
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
